// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive control for an 8-bit asynchronous serial link
// (8N1, LSB first, idle high). Expects serial_in from an upstream
// two-flop synchronizer. Detects the start edge, times bit periods,
// samples mid-bit, and loads a holding register read via data_ready /
// data_read, with framing and overrun flags.
//
// Optional feature: define UART_RX_PARITY_EN to add an even-parity bit
// between the data and stop bits and a parity_error output.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       serial_in,
    input  logic       data_read,
    output logic [7:0] rx_data,
    output logic       data_ready,
    output logic       framing_error,
    output logic       overrun_error
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        LOAD
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          prev;
    logic          stop_sample;
    logic          start_edge;
`ifdef UART_RX_PARITY_EN
    logic          parity_sample;
`endif

    assign start_edge = prev & ~serial_in;

    // Receive FSM, bit timing, sampling and registered holding outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            prev          <= 1'b1;
            stop_sample   <= 1'b1;
            rx_data       <= '0;
            data_ready    <= 1'b0;
            framing_error <= 1'b0;
            overrun_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_sample <= 1'b0;
            parity_error  <= 1'b0;
`endif
        end else begin
            prev <= serial_in;

            // Consumer read outside LOAD; LOAD below takes priority.
            if (data_read && state != LOAD) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start_edge) begin
                        state <= START;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (serial_in) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {serial_in, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt           <= '0;
                        parity_sample <= serial_in;
                        state         <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt         <= '0;
                        stop_sample <= serial_in;
                        state       <= LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LOAD: begin
                    cnt           <= '0;
                    state         <= IDLE;
                    rx_data       <= shift;
                    data_ready    <= 1'b1;
                    framing_error <= ~stop_sample;
                    overrun_error <= data_ready & ~data_read;
`ifdef UART_RX_PARITY_EN
                    parity_error  <= (^shift) ^ parity_sample;
`endif
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive control unit for an 8-bit asynchronous serial link (8N1, LSB first, idle high).
- Sits downstream of the team's two-flop input synchronizer. It detects the start bit, times the bit periods, samples the data and stop bits, and loads a holding register.
- Hands bytes to the consumer through a ready/read handshake, with framing and overrun flags.

Parameters:
- CLKS_PER_BIT, 10, clock cycles per serial bit; must be an even integer, 4 or greater.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high; sampled on the rising edge of clk.
- serial_in  input  1  synchronized serial line; idle 1.
- data_read  input  1  consumer pulse: holding register has been taken.
- rx_data  output  8  last received byte.
- data_ready  output  1  holding register holds an unread byte.
- framing_error  output  1  stop bit of the last loaded frame was 0.
- overrun_error  output  1  a byte was loaded while the previous byte was still unread.

Behaviour:
- Reset values (rst=1 at a clk edge; overrides all other activity, including mid-frame):
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - Previous-sample register=1.
  - rx_data=0x00; data_ready, framing_error and overrun_error all 0.
- Edge detect: registered prev=serial_in every cycle. start_edge = prev & ~serial_in.
- Cycle counter: width $clog2(CLKS_PER_BIT); cleared on every state change; otherwise increments.
- IDLE: when start_edge=1, go to START.
- START: at count == CLKS_PER_BIT/2-1, sample serial_in (mid start bit).
  - Sample is 1: false start; return to IDLE, no output change.
  - Sample is 0: go to DATA, bit counter=0.
- DATA: at count == CLKS_PER_BIT-1, sample serial_in.
  - Shift right; the new bit enters bit 7, so the first received bit ends in bit 0.
  - Bit counter increments; after the 8th sample, go to STOP.
- STOP: at count == CLKS_PER_BIT-1, capture the stop sample and go to LOAD.
- LOAD: lasts exactly one cycle, then returns to IDLE.
  - rx_data <= shift register; data_ready <= 1; framing_error <= ~stop_sample.
  - overrun_error <= 1 if data_ready=1 and data_read=0 in that cycle; otherwise 0.
- Samples land at the middle of each bit. LOAD starts 9.5*CLKS_PER_BIT+1 cycles after the falling edge of the start bit; data_ready is visible the cycle after that.
- Handshake:
  - data_read=1 outside LOAD clears data_ready and overrun_error on the next edge; rx_data and framing_error hold.
  - data_read=1 in the same cycle as LOAD: LOAD wins (data_ready=1, overrun_error=0).
  - data_read while data_ready=0: no effect.
- Framing error: a frame with stop=0 still loads rx_data and asserts data_ready. Framing_error holds until the next LOAD.
- Line changes in DATA/STOP are ignored except at the sample points. No new frame is detected until the FSM returns to IDLE.
- Back-to-back frames: a start edge on the cycle after LOAD is detected.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampled at count == CLKS_PER_BIT-1.
  - Adds output parity_error (1 bit, reset 0). At LOAD it is set to 1 if XOR of the 8 data bits and the parity bit is 1 (even parity); otherwise 0. It holds until the next LOAD.
  - LOAD latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity_error port; 8N1 only.

Test Plan:
- Reset with CLKS_PER_BIT=10: hold rst=1 for 2 cycles -> all outputs 0 and rx_data=0x00. Assert rst mid-DATA -> returns to IDLE, no data_ready.
- Send frame 0xA5 with stop=1 -> rx_data=0xA5, data_ready=1, framing_error=0. Pulse data_read -> data_ready=0 next cycle, rx_data stays 0xA5.
- Glitch: serial_in low for 3 cycles, then high -> false start, FSM back in IDLE, data_ready stays 0. A following 0x3C frame is received correctly.
- Send 0x81 with stop=0 -> rx_data=0x81, data_ready=1, framing_error=1. Next good frame 0x7E -> framing_error=0.
- Two frames 0x11 then 0x22 with no data_read -> rx_data=0x22, overrun_error=1. Repeat with data_read asserted in the LOAD cycle of 0x22 -> overrun_error=0, data_ready=1.
- UART_RX_PARITY_EN: 0x07 with parity bit 1 -> parity_error=0. 0x07 with parity bit 0 -> parity_error=1. Back-to-back frames are received without loss.
